// File: rtl/uart_tx.sv
// Serial UART transmitter: one byte per valid/ready handshake, framed as
// start bit, LSB-first data, optional parity and 1..2 stop bits, paced by baud_en.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PAR, STOP} state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 par_bit, par_bit_next;
  logic                 tx_next;

  assign tx_ready = (state == IDLE) && !rst;
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_next;
      tx       <= tx_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      par_bit  <= par_bit_next;
    end
  end

  // Each state names the bit currently on the line; tx is loaded with the
  // next bit on the baud_en edge that leaves the state.
  always_comb begin
    state_next    = state;
    tx_next       = tx;
    shreg_next    = shreg;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    par_bit_next  = par_bit;
    tx_done       = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_valid && tx_ready) begin
          shreg_next   = tx_data;
          bit_cnt_next = '0;
          par_bit_next = (PARITY == 2) ? ~^tx_data : ^tx_data;
          state_next   = SYNC;
        end
      end
      SYNC: begin
        if (baud_en) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_en) begin
          tx_next    = shreg[0];
          shreg_next = shreg >> 1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_en) begin
          if (bit_cnt == LAST_BIT) begin
            stop_cnt_next = 1'b0;
            if (PARITY != 0) begin
              tx_next    = par_bit;
              state_next = PAR;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            tx_next      = shreg[0];
            shreg_next   = shreg >> 1;
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      PAR: begin
        if (baud_en) begin
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end
      end
      STOP: begin
        if (baud_en) begin
          if (stop_cnt == LAST_STOP) begin
            tx_done    = !rst;
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share clk/rst/baud_en,
// every frame is checked clock by clock against hand-written bit strings.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       baud_en;
  logic       baud_gate;
  logic [7:0] tx_data;
  logic [3:0] valid_w;
  logic [3:0] ready_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int vectors     = 0;
  int miscompares = 0;
  int baud_cnt    = 0;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data), .tx_valid(valid_w[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data), .tx_valid(valid_w[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data), .tx_valid(valid_w[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data), .tx_valid(valid_w[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud pulse every 4 clk, updated just after the rising edge; baud_gate masks it.
  initial begin
    baud_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_cnt = (baud_cnt + 1) % 4;
      baud_en  = (baud_cnt == 3) && !baud_gate;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] obs(input logic [1:0] sel);
    return {tx_w[sel], done_w[sel], busy_w[sel], ready_w[sel]};
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed {tx,done,busy,ready}=%b expected %b", tag, observed, expected);
    end
  endtask

  // Called on a negedge with the selected DUT idle; returns on the negedge after the handshake.
  task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data);
    checkOutput($sformatf("accept_ready_%0d", sel), obs(sel), 4'b1001);
    tx_data      = data;
    valid_w[sel] = 1'b1;
    @(negedge clk);
    valid_w[sel] = 1'b0;
    tx_data      = ~data;
  endtask

  // Character i of frame is the i-th bit on the line; each bit must last exactly 4 clk.
  task automatic checkFrame(input logic [1:0] sel, input string frame, input int from,
                            input int upto, input string tag);
    int   waited;
    logic bit_exp;
    logic done_exp;
    if (from == 0) begin
      waited = 0;
      while (tx_w[sel] !== 1'b0 && waited < 12) begin
        @(negedge clk);
        waited++;
      end
      vectors++;
      assert (waited >= 1 && waited <= 4) else begin
        miscompares++;
        $error("[TB] FAIL %s start_latency: observed %0d clk, expected 1..4", tag, waited);
      end
    end
    for (int i = from; i < upto; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        bit_exp  = (frame[i] == "1");
        done_exp = (i == frame.len() - 1) && (k == 3);
        checkOutput($sformatf("%s bit%0d.%0d", tag, i, k), obs(sel), {bit_exp, done_exp, 1'b1, 1'b0});
      end
    end
    if (upto == frame.len()) begin
      @(negedge clk);
      checkOutput($sformatf("%s post_frame", tag), obs(sel), 4'b1001);
    end
  endtask

  initial begin
    rst       = 1'b1;
    baud_gate = 1'b0;
    tx_data   = 8'h00;
    valid_w   = 4'b0000;

    $display("[TB] reset");
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) checkOutput($sformatf("reset_%0d", s), obs(2'(s)), 4'b1000);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) checkOutput($sformatf("ready_after_reset_%0d", s), obs(2'(s)), 4'b1001);

    $display("[TB] 8N1 0xA5");
    applyStimulus(2'd0, 8'hA5);
    checkFrame(2'd0, "0101001011", 0, 10, "8n1_a5");

    $display("[TB] parity frames");
    applyStimulus(2'd1, 8'h07);
    checkFrame(2'd1, "01110000011", 0, 11, "8e1_07");
    applyStimulus(2'd2, 8'h07);
    checkFrame(2'd2, "01110000001", 0, 11, "8o1_07");
    applyStimulus(2'd1, 8'h00);
    checkFrame(2'd1, "00000000001", 0, 11, "8e1_00");

    $display("[TB] back-to-back with held valid");
    checkOutput("b2b_ready", obs(2'd0), 4'b1001);
    tx_data    = 8'h00;
    valid_w[0] = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    checkFrame(2'd0, "0000000001", 0, 10, "b2b_00");
    @(negedge clk);
    valid_w[0] = 1'b0;
    checkOutput("b2b_ready_drop", obs(2'd0), 4'b1010);
    checkFrame(2'd0, "0111111111", 0, 10, "b2b_ff");

    $display("[TB] reset during data bit 3");
    applyStimulus(2'd0, 8'h3C);
    checkFrame(2'd0, "0001111001", 0, 4, "abort_3c");
    @(negedge clk);
    checkOutput("abort_d3", obs(2'd0), 4'b1010);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_rst", obs(2'd0), 4'b1000);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      checkOutput("abort_idle", obs(2'd0), 4'b1001);
    end
    applyStimulus(2'd0, 8'h3C);
    checkFrame(2'd0, "0001111001", 0, 10, "resend_3c");

    $display("[TB] two stop bits and baud stall");
    applyStimulus(2'd3, 8'h5A);
    checkFrame(2'd3, "00101101011", 0, 11, "8n2_5a");
    applyStimulus(2'd3, 8'hC3);
    checkFrame(2'd3, "01100001111", 0, 2, "stall_c3");
    baud_gate = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("stall_hold", obs(2'd3), 4'b1010);
    end
    baud_gate = 1'b0;
    checkFrame(2'd3, "01100001111", 2, 11, "stall_c3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
